// File: rtl/fpu_round_if.sv
// fpu_round_if -- handshake and data bundle between the adder side, the
// rounding stage and the result consumer.
//
//   start      launch strobe, coincides with the adder's new_input
//   rm         rounding mode (00 RNE, 01 RTZ, 10 RUP, 11 RDN)
//   add_busy   adder still working; add_out not final while high
//   add_out    pre-rounded result {sign, exp[7:0], frac[22:0], G, R, S}
//   in_ready   start is accepted this cycle when high
//   res        rounded IEEE-754 single
//   res_valid  res and flags are valid
//   res_ready  consumer takes res this cycle
//   flags      {overflow, underflow, inexact}
//
// master = the environment (adder + consumer), slave = the rounding stage.
interface fpu_round_if;
  logic        start;
  logic [1:0]  rm;
  logic        add_busy;
  logic [34:0] add_out;
  logic        in_ready;
  logic [31:0] res;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  flags;

  modport master (
    output start, rm, add_busy, add_out, res_ready,
    input  in_ready, res, res_valid, flags
  );

  modport slave (
    input  start, rm, add_busy, add_out, res_ready,
    output in_ready, res, res_valid, flags
  );
endinterface

// File: rtl/fpu_round.sv
// fpu_round -- final rounding stage behind a floating-point adder.
//
// Accepts a start strobe together with a rounding mode, waits for the adder
// to drop add_busy, rounds its pre-rounded {sign, exp, frac, G, R, S} output
// to an IEEE-754 single and holds the registered result until the consumer
// takes it.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  fpu_round_if.slave (start/rm/add_busy/add_out in, in_ready/res/
//        res_valid/flags out, res_ready in)
module fpu_round (
  input  logic        clk,
  input  logic        rst,
  fpu_round_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  logic [1:0]  state;
  logic [1:0]  rm_q;
  logic [31:0] res_q;
  logic [2:0]  flags_q;

  // Rounding datapath (combinational, captured when the adder settles)
  logic        sign;
  logic [7:0]  exp_in;
  logic [22:0] frac_in;
  logic        g, r, s;
  logic        grs_any;
  logic        inc;
  logic        inc_rne;
  logic        at_max;
  logic        ovf;
  logic [30:0] mag;
  logic [31:0] rnd_res;
  logic [2:0]  rnd_flags;

  assign bus.in_ready  = (state == IDLE) || (state == HOLD && bus.res_ready);
  assign bus.res_valid = (state == HOLD);
  assign bus.res       = res_q;
  assign bus.flags     = flags_q;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sign    = bus.add_out[34];
    exp_in  = bus.add_out[33:26];
    frac_in = bus.add_out[25:3];
    g       = bus.add_out[2];
    r       = bus.add_out[1];
    s       = bus.add_out[0];
    grs_any = g | r | s;

    inc_rne = g & (r | s | frac_in[0]);
    case (rm_q)
      RM_RNE:  inc = inc_rne;
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & grs_any;
      default: inc = sign & grs_any;
    endcase

    // The fraction carry ripples into the exponent, which covers both the
    // subnormal->normal step and 1.fff..f -> 2.0.
    mag = {exp_in, frac_in} + {30'd0, inc};

    // With at most +1 ulp, the only finite magnitude that can reach exp FF
    // is max-finite. Overflow is judged on the mode's own rounding and also
    // on round-to-nearest, so truncating/directed modes still report a value
    // that lies beyond the halfway point above max-finite.
    at_max = (exp_in == 8'hFE) && (&frac_in);
    ovf    = at_max && (inc || inc_rne);

    rnd_res   = {sign, mag};
    rnd_flags = {1'b0, grs_any && (mag[30:23] == 8'h00), grs_any};

    if (exp_in == 8'hFF) begin
      // Inf passes through; NaN is quieted by forcing the top frac bit.
      rnd_flags = 3'b000;
      if (frac_in == 23'd0) rnd_res = {sign, 8'hFF, 23'd0};
      else                  rnd_res = {sign, 8'hFF, frac_in | 23'h400000};
    end else if (ovf) begin
      rnd_flags = 3'b101;
      case (rm_q)
        RM_RNE:  rnd_res = {sign, 8'hFF, 23'd0};
        RM_RTZ:  rnd_res = {sign, 8'hFE, 23'h7FFFFF};
        RM_RUP:  rnd_res = sign ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
        default: rnd_res = sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rm_q    <= RM_RNE;
      res_q   <= 32'd0;
      flags_q <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= WAIT;
            rm_q  <= bus.rm;
          end
        end
        // Entered the cycle after start, so add_busy in the start cycle
        // itself is never looked at.
        WAIT: begin
          if (!bus.add_busy) begin
            state   <= HOLD;
            res_q   <= rnd_res;
            flags_q <= rnd_flags;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            if (bus.start) begin
              state <= WAIT;
              rm_q  <= bus.rm;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_round.sv
// tb_fpu_round -- self-checking bench for fpu_round: table-driven rounding
// vectors through a scoreboard queue, plus hand-written handshake and reset
// sequences.
module tb_fpu_round;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fpu_round_if bus();

  fpu_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  rm;
    logic [34:0] add_out;
    logic [31:0] exp_res;
    logic [2:0]  exp_flags;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [34:0] mk(logic s, logic [7:0] e, logic [22:0] f, logic [2:0] grs);
    return {s, e, f, grs};
  endfunction

  function automatic vec_t mkv(string n, logic [1:0] m, logic [34:0] a,
                               logic [31:0] er, logic [2:0] ef);
    vec_t v;
    v.name = n; v.rm = m; v.add_out = a; v.exp_res = er; v.exp_flags = ef;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE (or HOLD with res_ready high).
  // Drives one start cycle and records the expected result if accepted.
  task automatic launch(string name, logic [1:0] m, logic [34:0] a,
                        logic [31:0] er, logic [2:0] ef);
    exp_t e;
    bus.start    = 1'b1;
    bus.rm       = m;
    bus.add_out  = a;
    bus.add_busy = 1'b0;
    #1;
    check({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) begin
      e.name = name; e.res = er; e.flags = ef;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: result 0x%08h with no expectation queued", bus.res);
      return;
    end
    e = sb_q.pop_front();
    check({e.name, ".res"}, bus.res, e.res);
    check({e.name, ".flags"}, 32'(bus.flags), 32'(e.flags));
  endtask

  // Called at the negedge after launch (DUT in WAIT). Keeps the adder busy
  // for `busy` cycles, then expects res_valid exactly one cycle after the
  // first not-busy cycle and checks the popped expectation.
  task automatic complete(string name, int busy);
    int guard;
    for (int i = 0; i < busy; i++) begin
      bus.add_busy = 1'b1;
      @(negedge clk);
      check({name, ".busy_valid"}, 32'(bus.res_valid), 32'd0);
      check({name, ".busy_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.add_busy = 1'b0;
    @(negedge clk);
    check({name, ".latency"}, 32'(bus.res_valid), 32'd1);
    guard = 0;
    while (!bus.res_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.res_valid) begin
      check({name, ".timeout"}, 32'(bus.res_valid), 32'd1);
      return;
    end
    pop_compare();
  endtask

  task automatic drain(string name);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, ".idle_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mkv("norm2",     RNE, mk(1'b0, 8'h80, 23'h000000, 3'b000), 32'h40000000, 3'b000));
    vecs.push_back(mkv("tie_odd",   RNE, mk(1'b0, 8'h7F, 23'h000001, 3'b100), 32'h3F800002, 3'b001));
    vecs.push_back(mkv("tie_even",  RNE, mk(1'b0, 8'h7F, 23'h000000, 3'b100), 32'h3F800000, 3'b001));
    vecs.push_back(mkv("carry",     RNE, mk(1'b0, 8'h7F, 23'h7FFFFF, 3'b110), 32'h40000000, 3'b001));
    vecs.push_back(mkv("sub_norm",  RNE, mk(1'b0, 8'h00, 23'h7FFFFF, 3'b110), 32'h00800000, 3'b001));
    vecs.push_back(mkv("tiny",      RNE, mk(1'b0, 8'h00, 23'h000001, 3'b010), 32'h00000001, 3'b011));
    vecs.push_back(mkv("ovf_rne",   RNE, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b100), 32'h7F800000, 3'b101));
    vecs.push_back(mkv("ovf_rtz",   RTZ, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b100), 32'h7F7FFFFF, 3'b101));
    vecs.push_back(mkv("ovf_rup_n", RUP, mk(1'b1, 8'hFE, 23'h7FFFFF, 3'b100), 32'hFF7FFFFF, 3'b101));
    vecs.push_back(mkv("ovf_rup_p", RUP, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b001), 32'h7F800000, 3'b101));
    vecs.push_back(mkv("ovf_rdn_n", RDN, mk(1'b1, 8'hFE, 23'h7FFFFF, 3'b100), 32'hFF800000, 3'b101));
    vecs.push_back(mkv("ovf_rdn_p", RDN, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b100), 32'h7F7FFFFF, 3'b101));
    vecs.push_back(mkv("max_rne",   RNE, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b001), 32'h7F7FFFFF, 3'b001));
    vecs.push_back(mkv("nan",       RNE, mk(1'b0, 8'hFF, 23'h000001, 3'b000), 32'h7FC00001, 3'b000));
    vecs.push_back(mkv("inf_neg",   RNE, mk(1'b1, 8'hFF, 23'h000000, 3'b000), 32'hFF800000, 3'b000));
    vecs.push_back(mkv("nan_grs",   RDN, mk(1'b1, 8'hFF, 23'h000010, 3'b111), 32'hFFC00010, 3'b000));
    vecs.push_back(mkv("rup_pos",   RUP, mk(1'b0, 8'h7F, 23'h000000, 3'b001), 32'h3F800001, 3'b001));
    vecs.push_back(mkv("rup_neg",   RUP, mk(1'b1, 8'h7F, 23'h000000, 3'b001), 32'hBF800000, 3'b001));
    vecs.push_back(mkv("rdn_neg",   RDN, mk(1'b1, 8'h7F, 23'h000000, 3'b001), 32'hBF800001, 3'b001));
    vecs.push_back(mkv("rdn_pos",   RDN, mk(1'b0, 8'h7F, 23'h000000, 3'b001), 32'h3F800000, 3'b001));
    vecs.push_back(mkv("rtz_trunc", RTZ, mk(1'b0, 8'h7F, 23'h7FFFFF, 3'b111), 32'h3FFFFFFF, 3'b001));
    vecs.push_back(mkv("rne_above", RNE, mk(1'b0, 8'h7F, 23'h000000, 3'b101), 32'h3F800001, 3'b001));
    vecs.push_back(mkv("rne_below", RNE, mk(1'b0, 8'h7F, 23'h000001, 3'b011), 32'h3F800001, 3'b001));
    vecs.push_back(mkv("zero_neg",  RNE, mk(1'b1, 8'h00, 23'h000000, 3'b000), 32'h80000000, 3'b000));
    vecs.push_back(mkv("uflow_rtz", RTZ, mk(1'b1, 8'h00, 23'h000000, 3'b001), 32'h80000000, 3'b011));

    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.rm        = 2'b00;
    bus.add_busy  = 1'b0;
    bus.add_out   = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.res_valid", 32'(bus.res_valid), 32'd0);
    check("rst.res", bus.res, 32'd0);
    check("rst.flags", 32'(bus.flags), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst.in_ready_after", 32'(bus.in_ready), 32'd1);

    // Table-driven rounding vectors, varied adder latency
    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i].name, vecs[i].rm, vecs[i].add_out, vecs[i].exp_res, vecs[i].exp_flags);
      complete(vecs[i].name, i % 3);
      drain(vecs[i].name);
    end

    // Handshake: long busy, held result, back-to-back start, ignored start
    launch("hs1", RUP, mk(1'b0, 8'h7F, 23'h000000, 3'b001), 32'h3F800001, 3'b001);
    complete("hs1", 7);
    bus.add_out = mk(1'b0, 8'h80, 23'h000000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hs1.hold_valid", 32'(bus.res_valid), 32'd1);
      check("hs1.hold_res", bus.res, 32'h3F800001);
      check("hs1.hold_flags", 32'(bus.flags), 32'd1);
    end
    bus.res_ready = 1'b1;
    launch("hs2", RUP, mk(1'b0, 8'h7F, 23'h000000, 3'b001), 32'h3F800001, 3'b001);
    bus.res_ready = 1'b0;
    bus.add_busy  = 1'b1;
    #1;
    check("hs2.wait_valid", 32'(bus.res_valid), 32'd0);
    bus.start = 1'b1;
    bus.rm    = RTZ;
    #1;
    check("hs2.ignored_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("hs2.still_wait", 32'(bus.res_valid), 32'd0);
    complete("hs2", 1);
    drain("hs2");

    // Reset while waiting on the adder
    launch("rw", RNE, mk(1'b0, 8'h80, 23'h000000, 3'b000), 32'h40000000, 3'b000);
    bus.add_busy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rw.res_valid", 32'(bus.res_valid), 32'd0);
    check("rw.res", bus.res, 32'd0);
    check("rw.flags", 32'(bus.flags), 32'd0);
    check("rw.in_ready", 32'(bus.in_ready), 32'd1);
    sb_q.delete();
    rst = 1'b1;
    bus.add_busy = 1'b0;
    @(negedge clk);
    check("rw.in_ready_after", 32'(bus.in_ready), 32'd1);
    check("rw.discarded", 32'(bus.res_valid), 32'd0);

    // Reset while holding a result
    launch("rh", RTZ, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b100), 32'h7F7FFFFF, 3'b101);
    complete("rh", 2);
    rst = 1'b0;
    @(negedge clk);
    check("rh.res_valid", 32'(bus.res_valid), 32'd0);
    check("rh.res", bus.res, 32'd0);
    check("rh.flags", 32'(bus.flags), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rh.in_ready_after", 32'(bus.in_ready), 32'd1);

    // Normal operation after reset; rm must come from the new start
    launch("post", RNE, mk(1'b0, 8'h7F, 23'h000001, 3'b100), 32'h3F800002, 3'b001);
    complete("post", 0);
    drain("post");

    check("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_round.md
FPU_ROUND -- requirements
Module: fpu_round

Interface
REQ-001 Port clk  in  1  single clock, rising-edge.
REQ-002 Port rst  in  1  reset, synchronous, active-low.
REQ-003 Port start  in  1  adder launched this cycle; pulse coincides with the adder's new_input.
REQ-004 Port rm  in  2  rounding mode, sampled on accepted start: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-005 Port add_busy  in  1  adder busy; result not final while high.
REQ-006 Port add_out  in  35  pre-rounded result: [34] sign, [33:26] exp, [25:3] frac, [2] G, [1] R, [0] S.
REQ-007 Port in_ready  out  1  start accepted this cycle when high.
REQ-008 Port res  out  32  rounded IEEE-754 single result.
REQ-009 Port res_valid  out  1  res and flags valid.
REQ-010 Port res_ready  in  1  consumer accepts res this cycle.
REQ-011 Port flags  out  3  {overflow, underflow, inexact}, valid with res_valid.

Function
REQ-012 FSM states: IDLE, WAIT, HOLD.
REQ-013 in_ready = (state==IDLE) || (state==HOLD && res_ready).
REQ-014 start && in_ready -> WAIT next cycle; rm latched; start with in_ready low is ignored, no state change.
REQ-015 WAIT: add_busy is not sampled in the start cycle; from the next cycle on, first cycle with add_busy==0 -> add_out rounded and registered into res/flags, -> HOLD.
REQ-016 Latency: res_valid rises the cycle after the first add_busy==0 cycle in WAIT.
REQ-017 HOLD: res_valid=1; res and flags held stable until res_ready.
REQ-018 HOLD && res_ready && !start -> IDLE.
REQ-019 HOLD && res_ready && start -> WAIT.
REQ-020 res_valid is 0 in IDLE and WAIT.
REQ-021 Round increment inc = RNE: G&&(R||S||frac[0]); RTZ: 0; RUP: !sign&&(G|R|S); RDN: sign&&(G|R|S).
REQ-022 Rounded magnitude = {exp,frac}+inc as 31-bit add; frac carry propagates into exp (subnormal->normal, 1.fff->2.0).
REQ-023 inexact = G|R|S for finite inputs.
REQ-024 Input exp==8'hFF bypasses rounding: frac==0 -> res={sign,FF,0}; frac!=0 -> res={sign,FF,frac|23'h400000} (quieted NaN); flags=000.
REQ-025 Rounded exp==8'hFF from finite input -> overflow=1, inexact=1.
REQ-026 On overflow, RNE -> +/-inf.
REQ-027 On overflow, RTZ -> {sign,FE,7FFFFF}.
REQ-028 On overflow, RUP -> +inf if sign=0, else -max finite.
REQ-029 On overflow, RDN -> -inf if sign=1, else +max finite.
REQ-030 underflow = inexact && rounded exp==0 (tininess after rounding).
REQ-031 Zero input with G=R=S=0 passes sign and zero through, flags=000.

Reset
REQ-032 rst==0 at a clock edge -> IDLE, res=0, flags=0, res_valid=0, rm=00, regardless of state; an in-flight operation is discarded.
REQ-033 in_ready=1 on the first cycle after reset release.

Verification
REQ-034 RNE, add_out={0,80,000000,000} -> res=0x40000000, flags=000; tie {0,7F,000001,100} -> 0x3F800002, inexact=1; {0,7F,000000,100} -> 0x3F800000, inexact=1.
REQ-035 RNE carry {0,7F,7FFFFF,110} -> 0x40000000, inexact=1; subnormal {0,00,7FFFFF,110} -> 0x00800000, underflow=0, inexact=1; {0,00,000001,010} RNE -> 0x00000001, underflow=1.
REQ-036 Overflow {0,FE,7FFFFF,100}: RNE -> 0x7F800000, flags=101; RTZ -> 0x7F7FFFFF, flags=101; sign=1 with RUP -> 0xFF7FFFFF.
REQ-037 NaN {0,FF,000001,000} -> 0x7FC00001, flags=000; inf {1,FF,000000,000} -> 0xFF800000.
REQ-038 Handshake: add_busy high 7 cycles after start -> res_valid rises the cycle after it drops; res_ready low 5 cycles -> res stable; res_ready and start together in HOLD -> in_ready=1, WAIT next cycle; start in WAIT ignored.
REQ-039 rst low during WAIT and during HOLD -> IDLE next cycle, res_valid=0, res=0, in_ready=1 after release.
